// File: rtl/inst_prefetch_pkg.sv
// Shared fetch-stage definitions: FSM encoding, instruction width and a word-align helper.
package inst_prefetch_pkg;

  localparam int INST_W = 32;

  typedef logic [INST_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  function automatic word_t word_align(input word_t a);
    return a & ~word_t'(3);
  endfunction

endpackage

// File: rtl/inst_prefetch_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect input and IF/ID output.
interface inst_prefetch_if;
  import inst_prefetch_pkg::*;

  logic  imem_req;
  word_t imem_addr;
  logic  imem_ack;
  word_t imem_data;
  logic  redirect;
  word_t redirect_pc;
  logic  id_ready;
  logic  out_valid;
  word_t out_pc;
  word_t out_inst;

  modport master (
    output imem_req, imem_addr, out_valid, out_pc, out_inst,
    input  imem_ack, imem_data, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_pc, out_inst,
    output imem_ack, imem_data, redirect, redirect_pc, id_ready
  );

endinterface

// File: rtl/fifo_pq.sv
// Prefetch queue of {pc, inst} entries with push, pop, flush and an occupancy count.
module fifo_pq
  import inst_prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  word_t                  push_pc,
  input  word_t                  push_inst,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output word_t                  head_pc,
  output word_t                  head_inst
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  word_t         pc_mem   [DEPTH];
  word_t         inst_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // NOTE: the storage sits in the reset branch on purpose: the head must read 0/0
  // while reset is held, so this array cannot be a reset-less RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: non-blocking updates let push and pop in one cycle both see the old pointers.
      if (push) begin
        pc_mem[wr_ptr]   <= push_pc;
        inst_mem[wr_ptr] <= push_inst;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_pc   = pc_mem[rd_ptr];
  assign head_inst = inst_mem[rd_ptr];

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetcher: fetch FSM and fetch PC feeding a small queue ahead of IF/ID.
module inst_prefetch
  import inst_prefetch_pkg::*;
#(
  parameter int    DEPTH    = 4,
  parameter word_t RESET_PC = 32'h0000_0000
) (
  input logic             clk,
  input logic             pcrst,
  inst_prefetch_if.master bus
);

  localparam int            CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_state_e  state, state_nxt;
  word_t         fpc, fpc_nxt;
  word_t         addr_q, addr_nxt;
  logic          req_q;
  logic          push, pop;
  logic [CW-1:0] count, count_nxt;
  word_t         redir_pc;
  word_t         head_pc, head_inst;

  assign redir_pc      = word_align(bus.redirect_pc);
  assign bus.out_valid = (count != '0);
  assign bus.out_pc    = head_pc;
  assign bus.out_inst  = head_inst;
  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;

  // A redirect voids both the pop and any push in its cycle.
  assign pop       = bus.out_valid && bus.id_ready && !bus.redirect;
  assign push      = (state == REQ) && bus.imem_ack && !bus.redirect;
  assign count_nxt = count + CW'(push) - CW'(pop);

  fifo_pq #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (pcrst),
    .push      (push),
    .push_pc   (addr_q),
    .push_inst (bus.imem_data),
    .pop       (pop),
    .flush     (bus.redirect),
    .count     (count),
    .head_pc   (head_pc),
    .head_inst (head_inst)
  );

  always_ff @(posedge clk or negedge pcrst) begin
    if (!pcrst) begin
      state  <= IDLE;
      req_q  <= 1'b0;
      addr_q <= RESET_PC;
      fpc    <= RESET_PC;
    end else begin
      state  <= state_nxt;
      req_q  <= (state_nxt != IDLE);
      addr_q <= addr_nxt;
      fpc    <= fpc_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    fpc_nxt   = fpc;
    unique case (state)
      IDLE: begin
        if (bus.redirect) begin
          state_nxt = REQ;
          addr_nxt  = redir_pc;
          fpc_nxt   = redir_pc;
        end else if (count_nxt < FULL) begin
          state_nxt = REQ;
          addr_nxt  = fpc;
        end
      end
      REQ: begin
        if (bus.redirect) begin
          fpc_nxt = redir_pc;
          if (bus.imem_ack) addr_nxt  = redir_pc;
          else              state_nxt = DROP;
        end else if (bus.imem_ack) begin
          fpc_nxt = addr_q + 32'd4;
          if (count_nxt < FULL) addr_nxt  = addr_q + 32'd4;
          else                  state_nxt = IDLE;
        end
      end
      DROP: begin
        // The outstanding response belongs to the old stream and is thrown away.
        if (bus.redirect) fpc_nxt = redir_pc;
        if (bus.imem_ack) begin
          state_nxt = REQ;
          addr_nxt  = bus.redirect ? redir_pc : fpc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/inst_prefetch.md
INST_PREFETCH -- requirements
Module: inst_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the queue entry count (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 pcrst  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 imem_req  out  1  SHALL be the registered instruction-memory read request.
REQ-006 imem_addr  out  32  SHALL be the registered word address, stable while imem_req=1.
REQ-007 imem_ack  in  1  SHALL mark imem_data valid and complete the request in the same cycle.
REQ-008 imem_data  in  32  SHALL carry the instruction word.
REQ-009 redirect  in  1  SHALL request a flush and refetch, for a branch or jump resolved downstream.
REQ-010 redirect_pc  in  32  SHALL carry the new fetch address; bits [1:0] are ignored and forced to 0.
REQ-011 id_ready  in  1  SHALL be 1 when the IF/ID register accepts an entry, i.e. it is not stalled.
REQ-012 out_valid  out  1  SHALL be 1 when out_pc/out_inst hold a valid queue head.
REQ-013 out_pc  out  32  SHALL be the head-entry fetch address.
REQ-014 out_inst  out  32  SHALL be the head-entry instruction.

Function
REQ-015 The queue SHALL be DEPTH entries of {pc, inst} with read/write pointers wrapping modulo DEPTH and a count of 0..DEPTH.
REQ-016 The outputs SHALL be driven combinationally from the head, with out_valid = (count != 0).
REQ-017 A pop SHALL occur when out_valid and id_ready are both 1, and it SHALL take effect at the clock edge.
REQ-018 The FSM SHALL have the states IDLE (req=0), REQ (req=1), and DROP (req=1, response discarded).
REQ-019 IDLE -> REQ SHALL occur when count_next < DEPTH; on entry, imem_addr = fpc.
REQ-020 REQ with ack SHALL push {imem_addr, imem_data} and set fpc = imem_addr+4 (wraps at 2^32).
REQ-021 It SHALL then stay in REQ with imem_addr = fpc+4 if count_next < DEPTH, else go to IDLE; this gives back-to-back one-per-cycle fetch on a zero-wait memory.
REQ-022 Here count_next = count + push - pop; overflow is impossible by construction, and a push while full SHALL never occur.
REQ-023 Once a request is issued, imem_req and imem_addr SHALL NOT change until ack.
REQ-024 Redirect handling SHALL be as follows:
- the queue is flushed (count=0, pointers=0) at that edge;
- fpc = redirect_pc;
- any pop in that cycle is void.
REQ-025 Redirect in IDLE SHALL go to REQ with imem_addr = redirect_pc.
REQ-026 Redirect in REQ with ack SHALL discard the data and re-enter REQ with imem_addr = redirect_pc.
REQ-027 Redirect in REQ without ack SHALL go to DROP, keeping imem_addr.
REQ-028 In DROP:
- ack discards the data and goes to REQ with imem_addr = fpc;
- a further redirect updates fpc and stays in DROP;
- redirect with ack in the same cycle goes to REQ with the newest redirect_pc.
REQ-029 out_valid SHALL be 0 in the cycle after any redirect.
REQ-030 Fetch-to-output latency SHALL be: ack at edge N gives out_valid=1 after edge N, when the queue was empty.

Reset
REQ-031 On pcrst=0, the block SHALL immediately have:
- state=IDLE, imem_req=0, imem_addr=RESET_PC;
- fpc=RESET_PC;
- count=0, pointers=0;
- out_valid=0, out_pc=0, out_inst=0 (queue storage cleared).
REQ-032 The first request SHALL be issued in the first cycle after pcrst deasserts, via IDLE->REQ at the first edge.
REQ-033 A reset asserted mid-request SHALL abandon it; the memory SHALL tolerate imem_req dropping before ack only under reset.

Structure
REQ-034 The shared CPU package SHALL hold the FSM state encoding (IDLE/REQ/DROP, 2 bits) and the instruction-width constant (32).
REQ-035 The storage SHALL be one sub-module, fifo_pq, parameterised by DEPTH, with push/pop/flush and count; the FSM and fpc SHALL live in inst_prefetch.

Verification
REQ-036 Reset release with a zero-wait memory (ack=req), mem[a]=a, id_ready=1 SHALL give imem_addr 0,4,8,... one per cycle, and out_pc/out_inst 0/0, 4/4, ... starting one cycle after the first ack.
REQ-037 id_ready=0 with DEPTH=4 SHALL give exactly 4 acks, then imem_req=0 and count=4. Raising id_ready SHALL give in-order output 0,4,8,C and resumption at addr 10.
REQ-038 A 3-cycle-latency memory with redirect to 0x100 mid-request SHALL give DROP, the old ack data absent from the output, then imem_addr=0x100 and first out_pc=0x100.
REQ-039 Redirect to 0x203 together with an ack and pop SHALL give the acked data dropped, out_valid=0 next cycle, and the next imem_addr=0x200.
REQ-040 Two redirects (0x40 then 0x80) during one outstanding request SHALL give the next issued address 0x80.
REQ-041 pcrst asserted mid-burst with 2 entries queued SHALL immediately give out_valid=0 and imem_req=0, and restart at RESET_PC after release.
